// File: rtl/zaxxon_wave_pkg.sv
// Shared constants and helpers for the Zaxxon wave-sample playback path.
package zaxxon_wave_pkg;

   localparam int NCH_DEFAULT = 4;

   // Byte addresses of each sample in the wave ROM; END is exclusive.
   localparam logic [19:0] WAVE_START [NCH_DEFAULT] = '{20'h00000, 20'h01000, 20'h02000, 20'h03000};
   localparam logic [19:0] WAVE_END   [NCH_DEFAULT] = '{20'h00006, 20'h0100A, 20'h02004, 20'h03008};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CAPTURE,
      ST_MIX
   } fsm_state_t;

   // Clamp a wide signed sum into the 16-bit PCM range.
   function automatic logic [15:0] sat16(input logic signed [31:0] x);
      if (x > 32'sd32767) begin
         return 16'h7FFF;
      end else if (x < -32'sd32768) begin
         return 16'h8000;
      end else begin
         return x[15:0];
      end
   endfunction

endpackage

// File: rtl/wave_rate_tick.sv
// Fractional-N sample-rate generator: one-cycle tick at SAMPLE_HZ on average.
module wave_rate_tick #(
   parameter int CLK_HZ    = 24000000,
   parameter int SAMPLE_HZ = 11025
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int ACC_W = $clog2(CLK_HZ) + 1;
   localparam int SUM_W = ACC_W + 1;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             tick_q, tick_d;
   logic [SUM_W-1:0] sum;

   // Add the sample rate each enabled cycle; wrap by CLK_HZ and flag the wrap.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      sum    = {1'b0, acc_q} + SUM_W'(SAMPLE_HZ);
      acc_d  = acc_q;
      tick_d = 1'b0;
      if (en) begin
         if (sum >= SUM_W'(CLK_HZ)) begin
            acc_d  = ACC_W'(sum - SUM_W'(CLK_HZ));
            tick_d = 1'b1;
         end else begin
            acc_d  = sum[ACC_W-1:0];
         end
      end
   end

   // Accumulator and tick registers.
   always_ff @(posedge clk_sys or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         acc_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/wave_sample_player.sv
// Multi-channel PCM sample player: one read sweep over all channels per sample tick,
// then a saturating mix into audio_out.
module wave_sample_player
   import zaxxon_wave_pkg::*;
#(
   parameter int NCH        = NCH_DEFAULT,
   parameter int CLK_HZ     = 24000000,
   parameter int SAMPLE_HZ  = 11025,
   parameter int RD_LATENCY = 4
) (
   input  logic           clk_sys,
   input  logic           reset,
   input  logic [NCH-1:0] trig,
   input  logic [NCH-1:0] loop,
   input  logic           pause,
   input  logic           dl_busy,
   output logic           wave_rd,
   output logic [19:0]    wave_addr,
   input  logic [15:0]    wave_data,
   output logic [15:0]    audio_out,
   output logic [NCH-1:0] active
);

   localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int MIX_W    = 16 + $clog2(NCH);
   localparam int WAIT_CNT = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

   if (NCH * (RD_LATENCY + 2) + 1 >= CLK_HZ / SAMPLE_HZ) begin : g_budget_check
      $error("wave_sample_player: a read sweep does not fit in one sample period");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_latency_check
      $error("wave_sample_player: RD_LATENCY must be within 1..15");
   end
   if (NCH > NCH_DEFAULT) begin : g_nch_check
      $error("wave_sample_player: more channels than sample address entries");
   end

   fsm_state_t         state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [3:0]         lat_q, lat_d;
   logic [19:0]        pos_q [NCH];
   logic [19:0]        pos_d [NCH];
   logic [15:0]        smp_q [NCH];
   logic [15:0]        smp_d [NCH];
   logic [NCH-1:0]     active_q, active_d;
   logic [NCH-1:0]     pend_q, pend_d;
   logic [NCH-1:0]     trig_q, trig_prev_q, trig_rise;
   logic [15:0]        audio_q, audio_d;
   logic               tick;
   logic               advance;
   logic [19:0]        cap_pos;
   logic [MIX_W-1:0]   mix_sum;

   wave_rate_tick #(
      .CLK_HZ   (CLK_HZ),
      .SAMPLE_HZ(SAMPLE_HZ)
   ) u_rate_tick (
      .clk_sys(clk_sys),
      .reset  (reset),
      .en     (~pause),
      .tick   (tick)
   );

   assign trig_rise = trig_q & ~trig_prev_q;

   // Channel start handling plus the sweep FSM next-state and read strobe.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      lat_d     = lat_q;
      pos_d     = pos_q;
      smp_d     = smp_q;
      active_d  = active_q;
      pend_d    = pend_q | trig_rise;
      audio_d   = audio_q;
      wave_rd   = 1'b0;
      wave_addr = '0;
      advance   = 1'b0;
      cap_pos   = '0;
      mix_sum   = '0;

      // Starts land on the tick, before the sweep reads, so a restart beats end-of-sample.
      if (tick) begin
         for (int i = 0; i < NCH; i++) begin
            if (pend_d[i]) begin
               pos_d[i]    = WAVE_START[i];
               active_d[i] = 1'b1;
            end
         end
         pend_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (tick && !pause && !dl_busy) begin
               ch_d    = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (active_q[ch_q]) begin
               wave_rd   = 1'b1;
               wave_addr = pos_q[ch_q];
               lat_d     = 4'(WAIT_CNT);
               state_d   = (RD_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
            end else begin
               smp_d[ch_q] = '0;
               advance     = 1'b1;
            end
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               state_d = ST_CAPTURE;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         ST_CAPTURE: begin
            smp_d[ch_q] = wave_data;
            cap_pos     = pos_q[ch_q] + 20'd2;
            pos_d[ch_q] = cap_pos;
            if (cap_pos == WAVE_END[ch_q]) begin
               if (loop[ch_q]) begin
                  pos_d[ch_q] = WAVE_START[ch_q];
               end else begin
                  active_d[ch_q] = 1'b0;
               end
            end
            advance = 1'b1;
         end
         ST_MIX: begin
            for (int i = 0; i < NCH; i++) begin
               mix_sum = mix_sum + {{(MIX_W-16){smp_q[i][15]}}, smp_q[i]};
            end
            audio_d = sat16({{(32-MIX_W){mix_sum[MIX_W-1]}}, mix_sum});
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (advance) begin
         if (ch_q == CH_W'(NCH - 1)) begin
            state_d = ST_MIX;
         end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = ST_ISSUE;
         end
      end

      if (dl_busy) begin
         audio_d = '0;
      end
   end

   // All player state; reset aborts any sweep in progress.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         lat_q       <= '0;
         // NOTE: the per-channel arrays are a handful of flops, not RAM, so they are reset like any register.
         pos_q       <= '{default: '0};
         smp_q       <= '{default: '0};
         active_q    <= '0;
         pend_q      <= '0;
         trig_q      <= '0;
         trig_prev_q <= '0;
         audio_q     <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         lat_q       <= lat_d;
         pos_q       <= pos_d;
         smp_q       <= smp_d;
         active_q    <= active_d;
         pend_q      <= pend_d;
         trig_q      <= trig;
         trig_prev_q <= trig_q;
         audio_q     <= audio_d;
      end
   end

   // A sample tick outside IDLE means the sweep overran its period.
   a_tick_in_idle: assert property (@(posedge clk_sys) disable iff (reset) tick |-> state_q == ST_IDLE);

   assign active    = active_q;
   assign audio_out = audio_q;

endmodule

// File: tb/tb_wave_sample_player.sv
// Self-checking bench for wave_sample_player with a fixed-latency memory responder
// and a per-sweep playback model.
module tb_wave_sample_player;
   import zaxxon_wave_pkg::*;

   localparam int NCH        = 4;
   localparam int CLK_HZ     = 1200000;
   localparam int SAMPLE_HZ  = 11025;
   localparam int RD_LATENCY = 4;
   localparam int PERIOD     = CLK_HZ / SAMPLE_HZ;

   logic           clk_sys = 1'b0;
   logic           reset;
   logic [NCH-1:0] trig;
   logic [NCH-1:0] loop;
   logic           pause;
   logic           dl_busy;
   logic           wave_rd;
   logic [19:0]    wave_addr;
   logic [15:0]    wave_data;
   logic [15:0]    audio_out;
   logic [NCH-1:0] active;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_sys = ~clk_sys;

   wave_sample_player #(
      .NCH       (NCH),
      .CLK_HZ    (CLK_HZ),
      .SAMPLE_HZ (SAMPLE_HZ),
      .RD_LATENCY(RD_LATENCY)
   ) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .trig     (trig),
      .loop     (loop),
      .pause    (pause),
      .dl_busy  (dl_busy),
      .wave_rd  (wave_rd),
      .wave_addr(wave_addr),
      .wave_data(wave_data),
      .audio_out(audio_out),
      .active   (active)
   );

   // Wave ROM contents: explicit table entries, a constant fill, or an address hash.
   logic [15:0] mem_tab [logic [19:0]];
   bit          use_fill = 1'b0;
   logic [15:0] fill_val = 16'h0000;

   function automatic logic [15:0] mem_val(input logic [19:0] a);
      logic [31:0] h;
      if (use_fill) return fill_val;
      if (mem_tab.exists(a)) return mem_tab[a];
      h = {12'h0, a} * 32'h0000_9E37;
      return h[15:0] ^ 16'h3C5A;
   endfunction

   // Fixed-latency responder: data for a read seen in cycle T is presented in cycle T+RD_LATENCY.
   logic        pipe_v [RD_LATENCY+1] = '{default: 1'b0};
   logic [19:0] pipe_a [RD_LATENCY+1] = '{default: 20'h0};
   logic [19:0] rd_log [$];

   always @(negedge clk_sys) begin
      for (int k = RD_LATENCY; k > 0; k--) begin
         pipe_v[k] = pipe_v[k-1];
         pipe_a[k] = pipe_a[k-1];
      end
      pipe_v[0] = (wave_rd === 1'b1);
      pipe_a[0] = wave_addr;
      if (wave_rd === 1'b1) rd_log.push_back(wave_addr);
      wave_data = pipe_v[RD_LATENCY] ? mem_val(pipe_a[RD_LATENCY]) : 16'hxxxx;
   end

   // Playback model: per-channel position and playing flag, advanced once per sweep.
   logic [19:0]    m_pos [NCH];
   logic [NCH-1:0] m_act;
   logic [NCH-1:0] m_pend;
   logic [15:0]    m_audio;
   logic [19:0]    exp_addrs [$];

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) m_pos[i] = '0;
      m_act   = '0;
      m_pend  = '0;
      m_audio = '0;
   endtask

   task automatic model_sweep();
      int                 sum;
      logic signed [15:0] v;
      sum       = 0;
      exp_addrs = {};
      for (int i = 0; i < NCH; i++) begin
         if (m_pend[i]) begin
            m_pos[i] = WAVE_START[i];
            m_act[i] = 1'b1;
         end
      end
      m_pend = '0;
      for (int i = 0; i < NCH; i++) begin
         if (m_act[i]) begin
            exp_addrs.push_back(m_pos[i]);
            v   = mem_val(m_pos[i]);
            sum = sum + int'(v);
            m_pos[i] = m_pos[i] + 20'd2;
            if (m_pos[i] == WAVE_END[i]) begin
               if (loop[i]) m_pos[i] = WAVE_START[i];
               else         m_act[i] = 1'b0;
            end
         end
      end
      if (sum > 32767)       m_audio = 16'h7FFF;
      else if (sum < -32768) m_audio = 16'h8000;
      else                   m_audio = 16'(sum);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      n_checks++;
      assert (obs >= lo && obs <= hi) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic trig_pulse(input logic [NCH-1:0] mask);
      @(negedge clk_sys);
      trig   = mask;
      m_pend = m_pend | mask;
      cycles(2);
      trig = '0;
      cycles(2);
   endtask

   // Wait for a read strobe beyond the first n_seen entries; a timeout counts as a failure.
   task automatic wait_read(input string tag, input int n_seen);
      int t;
      t = 0;
      while (rd_log.size() <= n_seen && t < 4 * PERIOD) begin
         @(negedge clk_sys);
         t++;
      end
      check({tag, " read seen"}, 32'(rd_log.size() > n_seen), 32'd1);
   endtask

   // One sweep: compare the read addresses, the mixed output and the playing flags.
   task automatic sweep_step(input string tag);
      model_sweep();
      rd_log = {};
      if (exp_addrs.size() == 0) begin
         cycles(2 * PERIOD + 10);
      end else begin
         wait_read(tag, 0);
         cycles(40);
      end
      check({tag, " nreads"}, 32'(rd_log.size()), 32'(exp_addrs.size()));
      for (int i = 0; i < exp_addrs.size() && i < rd_log.size(); i++) begin
         check($sformatf("%s addr%0d", tag, i), {12'h0, rd_log[i]}, {12'h0, exp_addrs[i]});
      end
      check({tag, " audio"}, {16'h0, audio_out}, {16'h0, m_audio});
      check({tag, " active"}, {28'h0, active}, {28'h0, m_act});
   endtask

   initial begin
      int          n0;
      int          cnt;
      int          total;
      int          exp_ticks;
      bit          stable;
      logic [15:0] a0;
      logic [NCH-1:0] mask;

      reset   = 1'b1;
      trig    = '0;
      loop    = '0;
      pause   = 1'b0;
      dl_busy = 1'b0;
      model_reset();

      // Reset state
      cycles(3);
      check("rst wave_rd", {31'h0, wave_rd}, 32'h0);
      check("rst wave_addr", {12'h0, wave_addr}, 32'h0);
      check("rst audio", {16'h0, audio_out}, 32'h0);
      check("rst active", {28'h0, active}, 32'h0);
      @(negedge clk_sys);
      reset = 1'b0;

      // Idle for 10 ms of playback time with no trigger
      rd_log = {};
      cycles(CLK_HZ / 100);
      check("idle reads", 32'(rd_log.size()), 32'd0);
      check("idle audio", {16'h0, audio_out}, 32'h0);
      check("idle active", {28'h0, active}, 32'h0);

      // Channel 0 one-shot
      mem_tab[20'h00000] = 16'h0100;
      mem_tab[20'h00002] = 16'h0200;
      mem_tab[20'h00004] = 16'h0300;
      trig_pulse(4'b0001);
      sweep_step("oneshot s1");
      sweep_step("oneshot s2");
      sweep_step("oneshot s3");
      sweep_step("oneshot s4");

      // Channel 0 looping
      loop = 4'b0001;
      trig_pulse(4'b0001);
      for (int i = 0; i < 4; i++) sweep_step($sformatf("loop s%0d", i + 1));

      // Tick rate: one read per tick with only channel 0 looping
      rd_log = {};
      cycles(12000);
      cnt       = rd_log.size();
      exp_ticks = int'((longint'(12000) * SAMPLE_HZ) / CLK_HZ);
      check_range("tick rate", cnt, exp_ticks - 1, exp_ticks + 1);
      wait_read("rate resync", rd_log.size());
      cycles(40);
      total = rd_log.size();
      for (int i = 0; i < total; i++) model_sweep();
      check("rate audio", {16'h0, audio_out}, {16'h0, m_audio});

      // Pause between sweeps
      pause  = 1'b1;
      a0     = audio_out;
      n0     = rd_log.size();
      stable = 1'b1;
      repeat (1000) begin
         @(negedge clk_sys);
         if (audio_out !== a0) stable = 1'b0;
      end
      check("pause audio stable", {31'h0, stable}, 32'h1);
      check("pause reads", 32'(rd_log.size()), 32'(n0));
      pause = 1'b0;
      sweep_step("pause resume");

      // Download in progress
      dl_busy = 1'b1;
      cycles(3);
      check("dl audio zero", {16'h0, audio_out}, 32'h0);
      n0 = rd_log.size();
      cycles(2 * PERIOD + 10);
      check("dl reads", 32'(rd_log.size()), 32'(n0));
      check("dl audio held zero", {16'h0, audio_out}, 32'h0);
      dl_busy = 1'b0;
      sweep_step("dl resume");

      // Saturation in both directions
      use_fill = 1'b1;
      fill_val = 16'h7000;
      loop     = 4'b1111;
      trig_pulse(4'b1111);
      sweep_step("sat pos");
      fill_val = 16'h9000;
      sweep_step("sat neg");
      use_fill = 1'b0;

      // Randomised triggers and loop levels
      for (int s = 0; s < 30; s++) begin
         loop = 4'($urandom_range(0, 15));
         mask = 4'($urandom_range(1, 15));
         if (m_act == '0 || $urandom_range(0, 2) != 0) trig_pulse(mask);
         sweep_step($sformatf("rand s%0d", s));
      end

      // Asynchronous reset while a read is outstanding
      loop = 4'b1111;
      trig_pulse(4'b1111);
      n0 = rd_log.size();
      wait_read("wait rst sync", n0);
      @(posedge clk_sys);
      #2 reset = 1'b1;
      #1;
      check("async rst wave_rd", {31'h0, wave_rd}, 32'h0);
      check("async rst active", {28'h0, active}, 32'h0);
      check("async rst audio", {16'h0, audio_out}, 32'h0);
      cycles(2);
      reset = 1'b0;
      model_reset();
      loop = '0;
      rd_log = {};
      cycles(2 * PERIOD + 10);
      check("post rst reads", 32'(rd_log.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
